// File: rtl/ltpi_pkg.sv
// Shared SMBus relay definitions for the LTPI link: event codes, relay FSM
// states and the event classification helpers used by every channel.
package ltpi_pkg;

    typedef enum logic [3:0] {
        EV_IDLE          = 4'd0,
        EV_START         = 4'd1,
        EV_START_RCV     = 4'd2,
        EV_DATA_0        = 4'd3,
        EV_DATA_1        = 4'd4,
        EV_BIT_RCV       = 4'd5,
        EV_STOP          = 4'd6,
        EV_STOP_RCV      = 4'd7,
        EV_START_ECHO    = 4'd8,
        EV_DATA_0_ECHO   = 4'd9,
        EV_DATA_1_ECHO   = 4'd10,
        EV_DATA_RCV_ECHO = 4'd11,
        EV_STOP_ECHO     = 4'd12
    } smbus_event_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_ECHO = 2'd2
    } echo_state_t;

    // Non-echo codes: delivered locally on change and answered with an echo.
    function automatic logic is_base_evt(input smbus_event_t e);
        return (e == EV_START) || (e == EV_DATA_0) || (e == EV_DATA_1) ||
               (e == EV_BIT_RCV) || (e == EV_STOP) || (e == EV_STOP_RCV) ||
               (e == EV_IDLE);
    endfunction

    function automatic logic is_data_evt(input smbus_event_t e);
        return (e == EV_DATA_0) || (e == EV_DATA_1) || (e == EV_BIT_RCV);
    endfunction

    function automatic logic is_repeated_evt(input smbus_event_t e);
        return is_data_evt(e) || (e == EV_DATA_0_ECHO) ||
               (e == EV_DATA_1_ECHO) || (e == EV_DATA_RCV_ECHO);
    endfunction

    // stop_rcv and idle have no dedicated echo and answer with idle.
    function automatic smbus_event_t echo_of(input smbus_event_t e);
        case (e)
            EV_START:   return EV_START_ECHO;
            EV_DATA_0:  return EV_DATA_0_ECHO;
            EV_DATA_1:  return EV_DATA_1_ECHO;
            EV_BIT_RCV: return EV_DATA_RCV_ECHO;
            EV_STOP:    return EV_STOP_ECHO;
            default:    return EV_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/smbus_echo_ch.sv
// One SMBus relay channel: receive delivery, echo generation, local event
// queue and the send / wait-for-echo / retry state machine.
module smbus_echo_ch
    import ltpi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_REPEAT = 3,
    parameter int MAX_RETRY   = 2,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] frame_ticks,
    input  logic             echo_en,
    input  logic [3:0]       rx_event,
    input  logic [3:0]       tx_event_req,
    input  logic             clear_status,
    output logic [3:0]       tx_event,
    output logic [3:0]       rx_event_local,
    output logic             fifo_overflow,
    output logic             echo_timeout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCW   = PTR_W + 1;
    localparam int HW    = CNT_W + 2;
    localparam int RW    = $clog2(MAX_RETRY + 2);

    smbus_event_t rx_in, req_in, rx_q, req_q, rx_local_q;
    smbus_event_t echo_q, fifo_head;
    logic         echo_valid_q;
    smbus_event_t fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [FCW-1:0]   fifo_cnt_q;

    echo_state_t  state_q, state_d;
    smbus_event_t tx_q, tx_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          seen_q, seen_d;
    logic          ovf_q, tmo_q;

    logic rx_change, echo_wr, push, fifo_full, push_ok;
    logic echo_pop, fifo_pop, timeout_set, overflow_set, needs_echo;
    logic [HW-1:0] ft_eff, reps, hold_ticks, wait_ticks;

    assign rx_in     = smbus_event_t'(rx_event);
    assign req_in    = smbus_event_t'(tx_event_req);
    assign rx_change = (rx_in != rx_q);
    assign echo_wr   = echo_en && rx_change && is_base_evt(rx_in);
    assign push      = (req_q == EV_IDLE) && (req_in != EV_IDLE);
    assign fifo_full = (fifo_cnt_q == FCW'(FIFO_DEPTH));
    assign push_ok   = push && (!fifo_full || fifo_pop);
    assign fifo_head = fifo_mem[rd_ptr_q];

    assign overflow_set = (echo_wr && echo_valid_q && !echo_pop) ||
                          (push && !push_ok);

    // Both products fit in CNT_W+2 bits, so the hold times never wrap.
    assign ft_eff     = (frame_ticks == '0) ? HW'(1) : {2'b00, frame_ticks};
    assign reps       = is_repeated_evt(tx_q) ? HW'(DATA_REPEAT) : HW'(1);
    assign hold_ticks = reps * ft_eff;
    assign wait_ticks = ft_eff << 2;
    assign needs_echo = echo_en && is_data_evt(tx_q);

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        seen_d      = seen_q || ((state_q != ST_IDLE) && needs_echo &&
                                 (rx_in == echo_of(tx_q)));
        echo_pop    = 1'b0;
        fifo_pop    = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d    = EV_IDLE;
                cnt_d   = '0;
                retry_d = '0;
                seen_d  = 1'b0;
                if (echo_valid_q) begin
                    tx_d     = echo_q;
                    echo_pop = 1'b1;
                    state_d  = ST_SEND;
                end else if (fifo_cnt_q != '0) begin
                    tx_d     = fifo_head;
                    fifo_pop = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cnt_q == hold_ticks - HW'(1)) begin
                    cnt_d = '0;
                    if (!needs_echo || seen_d) begin
                        state_d = ST_IDLE;
                        tx_d    = EV_IDLE;
                    end else begin
                        state_d = ST_WAIT_ECHO;
                    end
                end else begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            ST_WAIT_ECHO: begin
                if (!echo_en || seen_d) begin
                    state_d = ST_IDLE;
                    tx_d    = EV_IDLE;
                end else if (cnt_q == wait_ticks - HW'(1)) begin
                    cnt_d = '0;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_SEND;
                    end else begin
                        timeout_set = 1'b1;
                        state_d     = ST_IDLE;
                        tx_d        = EV_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = EV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q         <= EV_IDLE;
            req_q        <= EV_IDLE;
            rx_local_q   <= EV_IDLE;
            echo_q       <= EV_IDLE;
            echo_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            state_q      <= ST_IDLE;
            tx_q         <= EV_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            seen_q       <= 1'b0;
            ovf_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            rx_q       <= rx_in;
            req_q      <= req_in;
            rx_local_q <= (rx_change && is_base_evt(rx_in)) ? rx_in : EV_IDLE;
            // A same-cycle write wins over the pop, so both are honoured.
            if (echo_wr) begin
                echo_q       <= echo_of(rx_in);
                echo_valid_q <= 1'b1;
            end else if (echo_pop) begin
                echo_valid_q <= 1'b0;
            end
            if (push_ok)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fifo_cnt_q <= fifo_cnt_q + FCW'(push_ok) - FCW'(fifo_pop);
            state_q    <= state_d;
            tx_q       <= tx_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            seen_q     <= seen_d;
            if (clear_status)      ovf_q <= 1'b0;
            else if (overflow_set) ovf_q <= 1'b1;
            if (clear_status)      tmo_q <= 1'b0;
            else if (timeout_set)  tmo_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= req_in;
    end

    assign tx_event       = tx_q;
    assign rx_event_local = rx_local_q;
    assign fifo_overflow  = ovf_q;
    assign echo_timeout   = tmo_q;

endmodule

// File: rtl/smbus_echo_mc.sv
// Multi-channel SMBus echo relay: NUM_CH independent channels sharing only
// the frame length and the status-clear pulse.
module smbus_echo_mc
    import ltpi_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_REPEAT = 3,
    parameter int MAX_RETRY   = 2,
    parameter int CNT_W       = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CNT_W-1:0]       frame_ticks,
    input  logic [NUM_CH-1:0]      echo_en,
    input  logic [NUM_CH-1:0][3:0] rx_event,
    input  logic [NUM_CH-1:0][3:0] tx_event_req,
    input  logic                   clear_status,
    output logic [NUM_CH-1:0][3:0] tx_event,
    output logic [NUM_CH-1:0][3:0] rx_event_local,
    output logic [NUM_CH-1:0]      fifo_overflow,
    output logic [NUM_CH-1:0]      echo_timeout
);
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        smbus_echo_ch #(
            .FIFO_DEPTH  (FIFO_DEPTH),
            .DATA_REPEAT (DATA_REPEAT),
            .MAX_RETRY   (MAX_RETRY),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .frame_ticks    (frame_ticks),
            .echo_en        (echo_en[gi]),
            .rx_event       (rx_event[gi]),
            .tx_event_req   (tx_event_req[gi]),
            .clear_status   (clear_status),
            .tx_event       (tx_event[gi]),
            .rx_event_local (rx_event_local[gi]),
            .fifo_overflow  (fifo_overflow[gi]),
            .echo_timeout   (echo_timeout[gi])
        );
    end

endmodule

// File: tb/tb_smbus_echo_mc.sv
// Directed bench for smbus_echo_mc: channel 0 is exercised, its tx_event is
// logged as (code, length) runs and compared against hand-computed values.
module tb_smbus_echo_mc;
    import ltpi_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [11:0]      frame_ticks;
    logic [3:0]       echo_en;
    logic [3:0][3:0]  rx_event;
    logic [3:0][3:0]  tx_event_req;
    logic             clear_status;
    logic [3:0][3:0]  tx_event;
    logic [3:0][3:0]  rx_event_local;
    logic [3:0]       fifo_overflow;
    logic [3:0]       echo_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int ev;
        int len;
    } seg_t;
    seg_t segs[$];
    int   prev_tx = 0;
    int   run_len = 0;

    smbus_echo_mc dut (
        .clk            (clk),
        .reset          (reset),
        .frame_ticks    (frame_ticks),
        .echo_en        (echo_en),
        .rx_event       (rx_event),
        .tx_event_req   (tx_event_req),
        .clear_status   (clear_status),
        .tx_event       (tx_event),
        .rx_event_local (rx_event_local),
        .fifo_overflow  (fifo_overflow),
        .echo_timeout   (echo_timeout)
    );

    always #5 clk = ~clk;

    // Non-idle runs on channel 0's tx_event, sampled on the falling edge.
    always @(negedge clk) begin
        if (int'(tx_event[0]) != prev_tx) begin
            if (prev_tx != 0) segs.push_back('{prev_tx, run_len});
            prev_tx = int'(tx_event[0]);
            run_len = 1;
        end else begin
            run_len++;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        rx_event     = '0;
        tx_event_req = '0;
        clear_status = 1'b0;
        echo_en      = '1;
        repeat (2) tick();
        reset = 1'b0;
        segs.delete();
    endtask

    task automatic wait_segs(input int n, input int budget);
        int k = 0;
        while (segs.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (segs.size() < n) check_eq("seg_wait", segs.size(), n);
    endtask

    task automatic expect_seg(input string tag, input int ev, input int len);
        seg_t s;
        if (segs.size() == 0) begin
            check_eq({tag, "_present"}, 0, 1);
            return;
        end
        s = segs.pop_front();
        $display("[TB] %s: tx_event=%0d held %0d cycles (want %0d/%0d)",
                 tag, s.ev, s.len, ev, len);
        check_eq({tag, "_ev"}, s.ev, ev);
        check_eq({tag, "_len"}, s.len, len);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_ticks = 12'd10;
        do_reset();

        // Reset state
        check_eq("rst_tx", int'(tx_event), 0);
        check_eq("rst_rxloc", int'(rx_event_local), 0);
        check_eq("rst_ovf", int'(fifo_overflow), 0);
        check_eq("rst_tmo", int'(echo_timeout), 0);

        // Test 1: remote start -> start_echo for one frame, start delivered once
        rx_event[0] = EV_START;
        tick();
        check_eq("t1_rxloc_start", int'(rx_event_local[0]), int'(EV_START));
        tick();
        check_eq("t1_rxloc_idle", int'(rx_event_local[0]), int'(EV_IDLE));
        wait_segs(1, 100);
        expect_seg("t1_echo", int'(EV_START_ECHO), 10);

        // frame_ticks = 0 behaves as 1
        do_reset();
        frame_ticks = 12'd0;
        rx_event[0] = EV_START;
        wait_segs(1, 50);
        expect_seg("t1b_ft0", int'(EV_START_ECHO), 1);

        // Test 2: local data_1, echo arrives at cycle 15 of SEND
        do_reset();
        frame_ticks = 12'd10;
        tx_event_req[0] = EV_DATA_1;
        tick();
        tick();
        check_eq("t2_tx_first", int'(tx_event[0]), int'(EV_DATA_1));
        repeat (13) tick();
        rx_event[0] = EV_DATA_1_ECHO;
        tick();
        check_eq("t2_echo_not_local", int'(rx_event_local[0]), int'(EV_IDLE));
        wait_segs(1, 100);
        expect_seg("t2_data1", int'(EV_DATA_1), 30);
        check_eq("t2_tmo", int'(echo_timeout[0]), 0);

        // Test 3: bit_rcv with no echo -> 3 x (24 send + 32 wait), then timeout
        do_reset();
        frame_ticks = 12'd8;
        tx_event_req[0] = EV_BIT_RCV;
        repeat (100) tick();
        check_eq("t3_tmo_early", int'(echo_timeout[0]), 0);
        wait_segs(1, 400);
        expect_seg("t3_bitrcv", int'(EV_BIT_RCV), 168);
        check_eq("t3_tmo_set", int'(echo_timeout[0]), 1);
        check_eq("t3_ovf", int'(fifo_overflow[0]), 0);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check_eq("t3_tmo_clr", int'(echo_timeout[0]), 0);

        // Test 4: five pushes during one SEND; depth 4 keeps the first four
        do_reset();
        frame_ticks = 12'd10;
        echo_en[0] = 1'b0;
        tx_event_req[0] = EV_DATA_0;
        tick();
        tx_event_req[0] = EV_IDLE;
        tick();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       tx_event_req[0] = EV_START;
                1:       tx_event_req[0] = EV_STOP;
                2:       tx_event_req[0] = EV_START_RCV;
                3:       tx_event_req[0] = EV_STOP_RCV;
                default: tx_event_req[0] = EV_BIT_RCV;
            endcase
            tick();
            tx_event_req[0] = EV_IDLE;
            tick();
        end
        check_eq("t4_ovf", int'(fifo_overflow[0]), 1);
        wait_segs(5, 300);
        expect_seg("t4_s0", int'(EV_DATA_0), 30);
        expect_seg("t4_s1", int'(EV_START), 10);
        expect_seg("t4_s2", int'(EV_STOP), 10);
        expect_seg("t4_s3", int'(EV_START_RCV), 10);
        expect_seg("t4_s4", int'(EV_STOP_RCV), 10);
        repeat (40) tick();
        check_eq("t4_no_extra", segs.size(), 0);
        check_eq("t4_ch1_tx", int'(tx_event[1]), 0);
        check_eq("t4_ch1_ovf", int'(fifo_overflow[1]), 0);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check_eq("t4_ovf_clr", int'(fifo_overflow[0]), 0);

        // Test 5: echo write and local push together; echo goes first
        do_reset();
        frame_ticks = 12'd10;
        rx_event[0]     = EV_START;
        tx_event_req[0] = EV_STOP;
        tick();
        wait_segs(2, 200);
        expect_seg("t5_echo", int'(EV_START_ECHO), 10);
        expect_seg("t5_local", int'(EV_STOP), 10);
        check_eq("t5_ovf", int'(fifo_overflow[0]), 0);
        tx_event_req[0] = EV_IDLE;
        tick();
        tx_event_req[0] = EV_START;
        tick();
        repeat (4) tick();
        check_eq("t5_mid_send", int'(tx_event[0]), int'(EV_START));
        reset = 1'b1;
        tick();
        check_eq("t5_rst_tx", int'(tx_event[0]), int'(EV_IDLE));
        reset = 1'b0;

        // Test 6: echo slot overwrite sets overflow; clear wins over a set
        do_reset();
        frame_ticks = 12'd10;
        rx_event[0] = EV_START;
        repeat (4) tick();
        rx_event[0] = EV_STOP;
        tick();
        check_eq("t6_no_ovf", int'(fifo_overflow[0]), 0);
        rx_event[0] = EV_START;
        tick();
        check_eq("t6_ovf", int'(fifo_overflow[0]), 1);
        rx_event[0]  = EV_STOP;
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        check_eq("t6_clr_prio", int'(fifo_overflow[0]), 0);
        wait_segs(2, 200);
        expect_seg("t6_first", int'(EV_START_ECHO), 10);
        expect_seg("t6_second", int'(EV_STOP_ECHO), 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
